io_nwell_bias_seq: RTL

- Power-sequencing controller for the IO ring n-well bias supply cell (VNW) and the pad drivers that depend on it.
- Powers up in this order: wait for VDDIO power-good, enable VNW bias, wait for settle, release pad retention, enable pad drivers.
- Powers down in the reverse order, with drain timers between steps.
- Sits in the always-on chip-level power controller, next to the IO ring.

---
 rtl/io_nwell_bias_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/io_nwell_bias_seq.sv
// IO ring n-well bias power sequencer: VDDIO good -> bias on -> settle -> release retention -> pads on.
// Power-down runs in reverse with drain timers; all outputs are registered Moore decodes of the next state.
module io_nwell_bias_seq #(
  parameter int CNT_W         = 16,
  parameter int SETTLE_CYCLES = 256,
  parameter int DRAIN_CYCLES  = 64,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       pg_vddio_i,
  output logic       bias_en_o,
  output logic       ret_o,
  output logic       pad_en_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_OFF         = 3'd0,
    S_WAIT_PG     = 3'd1,
    S_BIAS_SETTLE = 3'd2,
    S_RELEASE     = 3'd3,
    S_READY       = 3'd4,
    S_PAD_DOWN    = 3'd5,
    S_BIAS_DOWN   = 3'd6,
    S_ILLEGAL     = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(DRAIN_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_fault;
  logic                   r_bias_en;
  logic                   r_ret;
  logic                   r_pad_en;
  logic                   r_ready;

  logic                   w_pg_s;
  logic                   w_cnt_zero;
  state_t                 w_nxt_state;
  logic [CNT_W-1:0]       w_nxt_cnt;
  logic                   w_nxt_fault;

  assign w_pg_s     = r_sync[SYNC_STAGES-1];
  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pg_vddio_i};
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_fault = r_fault;
    case (r_state)
      S_OFF: begin
        if (!en_i) begin
          w_nxt_fault = 1'b0;
        end else if (!r_fault) begin
          w_nxt_state = S_WAIT_PG;
        end
      end
      S_WAIT_PG: begin
        if (!en_i) begin
          w_nxt_state = S_OFF;
        end else if (w_pg_s) begin
          w_nxt_state = S_BIAS_SETTLE;
          w_nxt_cnt   = SETTLE_LD;
        end
      end
      S_BIAS_SETTLE, S_RELEASE: begin
        // Pads were never enabled, so an abort skips the pad drain
        if (!en_i || !w_pg_s) begin
          w_nxt_state = S_BIAS_DOWN;
          w_nxt_cnt   = DRAIN_LD;
          w_nxt_fault = r_fault | ~w_pg_s;
        end else if (r_state == S_RELEASE) begin
          w_nxt_state = S_READY;
        end else if (w_cnt_zero) begin
          w_nxt_state = S_RELEASE;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_READY: begin
        if (!en_i || !w_pg_s) begin
          w_nxt_state = S_PAD_DOWN;
          w_nxt_cnt   = DRAIN_LD;
          w_nxt_fault = r_fault | ~w_pg_s;
        end
      end
      S_PAD_DOWN: begin
        // pg loss only flags the fault; the drain still runs its full length
        w_nxt_fault = r_fault | ~w_pg_s;
        if (w_cnt_zero) begin
          w_nxt_state = S_BIAS_DOWN;
          w_nxt_cnt   = DRAIN_LD;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_BIAS_DOWN: begin
        if (w_cnt_zero) begin
          w_nxt_state = S_OFF;
        end else begin
          w_nxt_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = S_BIAS_DOWN;
        w_nxt_cnt   = DRAIN_LD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_OFF;
      r_cnt     <= '0;
      r_fault   <= 1'b0;
      r_bias_en <= 1'b0;
      r_ret     <= 1'b1;
      r_pad_en  <= 1'b0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_nxt_cnt;
      r_fault   <= w_nxt_fault;
      r_bias_en <= (w_nxt_state == S_BIAS_SETTLE) || (w_nxt_state == S_RELEASE) ||
                   (w_nxt_state == S_READY)       || (w_nxt_state == S_PAD_DOWN);
      r_ret     <= !((w_nxt_state == S_RELEASE) || (w_nxt_state == S_READY));
      r_pad_en  <= (w_nxt_state == S_READY);
      r_ready   <= (w_nxt_state == S_READY);
    end
  end

  assign bias_en_o = r_bias_en;
  assign ret_o     = r_ret;
  assign pad_en_o  = r_pad_en;
  assign ready_o   = r_ready;
  assign fault_o   = r_fault;
  assign state_o   = r_state;

endmodule
